id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and a saturating backpressure (stall) counter.
module id_ex_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_AW     = 5,
  parameter int CTRL_W     = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc4,
  input  logic [DATA_WIDTH-1:0] in_pc_imm,
  input  logic [DATA_WIDTH-1:0] in_imme,
  input  logic [DATA_WIDTH-1:0] in_srca,
  input  logic [DATA_WIDTH-1:0] in_srcb,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc4,
  output logic [DATA_WIDTH-1:0] out_pc_imm,
  output logic [DATA_WIDTH-1:0] out_imme,
  output logic [DATA_WIDTH-1:0] out_srca,
  output logic [DATA_WIDTH-1:0] out_srcb,
  output logic [REG_AW-1:0]     out_rs1,
  output logic [REG_AW-1:0]     out_rs2,
  output logic [REG_AW-1:0]     out_rd,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PW = 5 * DATA_WIDTH + 3 * REG_AW + CTRL_W;

  logic [PW-1:0]    in_pay_s;
  logic [PW-1:0]    main_pay_q, main_pay_d;
  logic [PW-1:0]    skid_pay_q, skid_pay_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             accept_s;
  logic             pop_s;

  assign in_pay_s = {in_pc4, in_pc_imm, in_imme, in_srca, in_srcb,
                     in_rs1, in_rs2, in_rd, in_ctrl};
  assign {out_pc4, out_pc_imm, out_imme, out_srca, out_srcb,
          out_rs1, out_rs2, out_rd, out_ctrl} = main_pay_q;

  assign out_valid = main_v_q;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_cnt_q;

  assign accept_s = in_valid & in_ready_q;
  assign pop_s    = ~main_v_q | out_ready;

  // Next-state for the two-entry FIFO, its ready flag and the stall counter
  always_comb begin
    main_pay_d  = main_pay_q;
    skid_pay_d  = skid_pay_q;
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // Zeroed payload keeps forwarding logic from seeing a stale rd writer
      main_v_d   = 1'b0;
      skid_v_d   = 1'b0;
      main_pay_d = {PW{1'b0}};
      skid_pay_d = {PW{1'b0}};
    end else if (pop_s) begin
      if (skid_v_q) begin
        main_pay_d = skid_pay_q;
        main_v_d   = 1'b1;
        skid_v_d   = 1'b0;
      end else begin
        if (accept_s) begin
          main_pay_d = in_pay_s;
        end else begin
          main_pay_d = main_pay_q;
        end
        main_v_d = accept_s;
      end
    end else begin
      if (accept_s) begin
        skid_pay_d = in_pay_s;
        skid_v_d   = 1'b1;
      end else begin
        skid_v_d = skid_v_q;
      end
    end

    if (main_v_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    in_ready_d = ~skid_v_d;
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      main_pay_q  <= {PW{1'b0}};
      skid_pay_q  <= {PW{1'b0}};
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      main_pay_q  <= main_pay_d;
      skid_pay_q  <= skid_pay_d;
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_id_ex_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [63:0] pc4;
    logic [63:0] pc_imm;
    logic [63:0] imme;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } pay_t;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  pay_t in_p, out_p;
  logic [CNT_W-1:0] stall_cnt;

  id_ex_stage #(.DATA_WIDTH(64), .REG_AW(5), .CTRL_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_p.pc4), .in_pc_imm(in_p.pc_imm), .in_imme(in_p.imme),
    .in_srca(in_p.srca), .in_srcb(in_p.srcb),
    .in_rs1(in_p.rs1), .in_rs2(in_p.rs2), .in_rd(in_p.rd), .in_ctrl(in_p.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc4(out_p.pc4), .out_pc_imm(out_p.pc_imm), .out_imme(out_p.imme),
    .out_srca(out_p.srca), .out_srcb(out_p.srcb),
    .out_rs1(out_p.rs1), .out_rs2(out_p.rs2), .out_rd(out_p.rd), .out_ctrl(out_p.ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  pay_t q[$];
  logic m_ready = 1'b1;
  int   m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pay(input string name, input pay_t act, input pay_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t rnd_pay();
    logic [350:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v = (v << 32) | 351'($urandom);
    return pay_t'(v);
  endfunction

  function automatic pay_t mk(input logic [63:0] pc4, input logic [4:0] rd);
    pay_t p;
    p = rnd_pay();
    p.pc4 = pc4;
    p.rd  = rd;
    return p;
  endfunction

  // One clock: advance the model with the current inputs, then compare at negedge.
  task automatic cycle();
    pay_t prev_p;
    logic was_stall;
    logic acc;
    prev_p    = out_p;
    was_stall = out_valid && !out_ready && !rst && !flush;
    acc       = in_valid && m_ready;
    if (rst) begin
      q.delete();
      m_cnt   = 0;
      m_ready = 1'b1;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(in_p);
      end
      m_ready = (q.size() < 2);
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (q.size() > 0) chk_pay("payload", out_p, q[0]);
    if (was_stall) chk_pay("stable", out_p, prev_p);
  endtask

  task automatic drive(input logic v, input pay_t p, input logic ordy);
    in_valid  = v;
    in_p      = p;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset then stream
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_rd", 64'(out_p.rd), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(64'(4 * (k + 1)), 5'(k + 1)), 1'b1);
      cycle();
      chk("stream_pc4", out_p.pc4, 64'(4 * (k + 1)));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, 1'b1);
    cycle();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Skid fill and drain
    drive(1'b1, mk(64'h4, 5'd1), 1'b0); cycle();
    drive(1'b1, mk(64'h8, 5'd2), 1'b0); cycle();
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_main", out_p.pc4, 64'h4);
    drive(1'b0, '0, 1'b1); cycle();
    chk("skid_second", out_p.pc4, 64'h8);
    chk("skid_ready_back", 64'(in_ready), 64'd1);
    cycle();
    chk("skid_empty", 64'(out_valid), 64'd0);

    // Flush with full skid and a rd=7 payload offered
    drive(1'b1, mk(64'h20, 5'd3), 1'b0); cycle();
    drive(1'b1, mk(64'h24, 5'd4), 1'b0); cycle();
    drive(1'b1, mk(64'h28, 5'd7), 1'b0); flush = 1'b1; cycle();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_rd", 64'(out_p.rd), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    // Flush with only main full, so the rd=7 offer would otherwise be accepted
    drive(1'b1, mk(64'h30, 5'd5), 1'b0); cycle();
    drive(1'b1, mk(64'h34, 5'd7), 1'b1); flush = 1'b1; cycle();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1); cycle();
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_rd", 64'(out_p.rd), 64'd0);

    // Reset mid-stall at stall_cnt=5
    rst = 1'b1; cycle(); rst = 1'b0;
    drive(1'b1, mk(64'h40, 5'd8), 1'b0); cycle();
    drive(1'b1, mk(64'h44, 5'd9), 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && m_cnt != 5; i++) cycle();
    chk("mid_stall_cnt", 64'(stall_cnt), 64'd5);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mid_rst_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pc4", out_p.pc4, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    // Saturation
    drive(1'b1, mk(64'h50, 5'd10), 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt", 64'(stall_cnt), 64'd15);
    flush = 1'b1; cycle(); flush = 1'b0;
    cycle();
    chk("sat_after_flush", 64'(stall_cnt), 64'd15);

    // Random traffic
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_pay(), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 1023) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
